mem_request_unit: RTL and testbench

//  Parametrised memory request unit for the RISC-V core. Arbitrates instruction fetch and data

---
 rtl/mem_request_unit.sv | 128 ++++++++++++
 tb/tb_mem_request_unit.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_request_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_request_unit
// Brief    : Arbitrates instruction fetch and data load/store onto one shared
//            fixed-latency RAM port with stall support and ready pulses.
// Revision : 1.0 - initial release
// ============================================================================
module mem_request_unit #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int LATENCY  = 2,
  parameter int PRIORITY = 0
) (
  input  logic              clk,
  input  logic              nRST,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ready,
  input  logic              d_ren,
  input  logic              d_wen,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_ren,
  output logic              ram_wen,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic              ram_busy,
  output logic              busy
);

  localparam int               c_CNT_W      = $clog2(LATENCY + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(LATENCY - 1);
  localparam logic             c_DATA_FIRST = (PRIORITY != 0);

  localparam logic [1:0] c_IDLE   = 2'd0;
  localparam logic [1:0] c_ACCESS = 2'd1;
  localparam logic [1:0] c_RESP   = 2'd2;

  logic [1:0]         r_state;
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_is_fetch;
  logic               r_is_write;
  logic               r_last_data;
  logic [ADDR_W-1:0]  r_ram_addr;
  logic [DATA_W-1:0]  r_ram_wdata;
  logic [DATA_W-1:0]  r_i_rdata;
  logic [DATA_W-1:0]  r_d_rdata;

  logic w_fetch_pend;
  logic w_data_pend;
  logic w_any_pend;
  logic w_grant_data;

  assign w_fetch_pend = i_req;
  assign w_data_pend  = d_ren | d_wen;
  assign w_any_pend   = w_fetch_pend | w_data_pend;

  // On collision round-robin picks whichever kind was not granted last.
  assign w_grant_data = w_data_pend & (~w_fetch_pend | c_DATA_FIRST | ~r_last_data);

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      r_state     <= c_IDLE;
      r_cnt       <= '0;
      r_is_fetch  <= 1'b0;
      r_is_write  <= 1'b0;
      r_last_data <= 1'b1;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
      r_i_rdata   <= '0;
      r_d_rdata   <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (w_any_pend) begin
            r_state     <= c_ACCESS;
            r_cnt       <= c_CNT_LOAD;
            r_is_fetch  <= ~w_grant_data;
            r_is_write  <= w_grant_data & d_wen;
            r_last_data <= w_grant_data;
            if (w_grant_data) begin
              r_ram_addr  <= d_addr;
              r_ram_wdata <= d_wdata;
            end else begin
              r_ram_addr  <= i_addr;
            end
          end
        end
        c_ACCESS: begin
          if (!ram_busy) begin
            if (r_cnt == '0) begin
              r_state <= c_RESP;
              if (r_is_fetch) begin
                r_i_rdata <= ram_rdata;
              end else if (!r_is_write) begin
                r_d_rdata <= ram_rdata;
              end
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
          end
        end
        c_RESP: begin
          r_state <= c_IDLE;
        end
        default: begin
          r_state <= c_IDLE;
        end
      endcase
    end
  end

  assign ram_addr  = r_ram_addr;
  assign ram_wdata = r_ram_wdata;
  assign ram_ren   = (r_state == c_ACCESS) & ~r_is_write;
  assign ram_wen   = (r_state == c_ACCESS) &  r_is_write;
  assign i_rdata   = r_i_rdata;
  assign d_rdata   = r_d_rdata;
  assign i_ready   = (r_state == c_RESP) &  r_is_fetch;
  assign d_ready   = (r_state == c_RESP) & ~r_is_fetch;
  assign busy      = (r_state == c_ACCESS) | (r_state == c_RESP);

endmodule
`default_nettype wire

// File: tb/tb_mem_request_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_request_unit
// Brief    : Randomized scoreboard bench for mem_request_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_request_unit;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic nRST = 1'b0;
  always #5 clk = ~clk;

  logic        i_req, i_ready, d_ren, d_wen, d_ready, ram_ren, ram_wen, ram_busy, busy;
  logic [31:0] i_addr, i_rdata, d_addr, d_wdata, d_rdata, ram_addr, ram_wdata, ram_rdata;

  logic        p1_i_req, p1_i_ready, p1_d_ren, p1_d_wen, p1_d_ready, p1_ram_ren, p1_ram_wen, p1_busy;
  logic [31:0] p1_i_addr, p1_i_rdata, p1_d_addr, p1_d_wdata, p1_d_rdata, p1_ram_addr, p1_ram_wdata, p1_ram_rdata;
  logic        p1_ram_busy = 1'b0;

  function automatic logic [31:0] ramf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
  endfunction

  assign ram_rdata    = ramf(ram_addr);
  assign p1_ram_rdata = ramf(p1_ram_addr);

  mem_request_unit #(.ADDR_W(32), .DATA_W(32), .LATENCY(LAT), .PRIORITY(0)) dut (
    .clk(clk), .nRST(nRST), .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
    .d_ren(d_ren), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ready(d_ready),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_ren(ram_ren), .ram_wen(ram_wen),
    .ram_rdata(ram_rdata), .ram_busy(ram_busy), .busy(busy));

  mem_request_unit #(.ADDR_W(32), .DATA_W(32), .LATENCY(LAT), .PRIORITY(1)) dut_p1 (
    .clk(clk), .nRST(nRST), .i_req(p1_i_req), .i_addr(p1_i_addr), .i_rdata(p1_i_rdata), .i_ready(p1_i_ready),
    .d_ren(p1_d_ren), .d_wen(p1_d_wen), .d_addr(p1_d_addr), .d_wdata(p1_d_wdata), .d_rdata(p1_d_rdata), .d_ready(p1_d_ready),
    .ram_addr(p1_ram_addr), .ram_wdata(p1_ram_wdata), .ram_ren(p1_ram_ren), .ram_wen(p1_ram_wen),
    .ram_rdata(p1_ram_rdata), .ram_busy(p1_ram_busy), .busy(p1_busy));

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          is_fetch;
    bit          is_write;
    logic [31:0] addr;
    logic [31:0] wdata;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  bit          last_data;
  bit          busy_en;
  bit          p1_done;
  logic [31:0] exp_irdata, exp_drdata;
  int          n_acc, n_busy;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // RAM stall generator: changes away from the edge so it is stable when sampled.
  initial begin
    ram_busy = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      ram_busy = busy_en && nRST && ($urandom_range(0, 3) == 0);
    end
  end

  // Monitor: checks the RAM side against the head transaction, pops on ready.
  initial begin
    n_acc = 0;
    n_busy = 0;
    forever begin
      @(negedge clk);
      if (!nRST) begin
        n_acc = 0;
        n_busy = 0;
      end else begin
        if (ram_ren || ram_wen) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_access", 1, 0);
          end else begin
            mon_e = exp_q[0];
            chk("ram_addr", ram_addr, mon_e.addr);
            chk("ram_wen", {31'd0, ram_wen}, {31'd0, mon_e.is_write});
            chk("ram_ren", {31'd0, ram_ren}, {31'd0, !mon_e.is_write});
            if (mon_e.is_write) chk("ram_wdata", ram_wdata, mon_e.wdata);
          end
          n_acc++;
          if (ram_busy) n_busy++;
        end
        chk("busy", {31'd0, busy}, {31'd0, (ram_ren | ram_wen | i_ready | d_ready)});
        if (i_ready || d_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_ready", 1, 0);
          end else begin
            mon_e = exp_q.pop_front();
            chk("i_ready", {31'd0, i_ready}, {31'd0, mon_e.is_fetch});
            chk("d_ready", {31'd0, d_ready}, {31'd0, !mon_e.is_fetch});
            chk("access_cycles", n_acc, LAT + n_busy);
            if (mon_e.is_fetch) exp_irdata = ramf(mon_e.addr);
            else if (!mon_e.is_write) exp_drdata = ramf(mon_e.addr);
            chk("i_rdata", i_rdata, exp_irdata);
            chk("d_rdata", d_rdata, exp_drdata);
          end
          n_acc = 0;
          n_busy = 0;
        end
      end
    end
  end

  // kind: 0 fetch, 1 read, 2 write, 3 read+write, 4 fetch collides with random data op.
  task automatic run_txn(input int kind, input bit drop);
    exp_t ef, ed;
    int   dtype, pending, cyc, stalls;
    bit   dfirst;
    dtype = (kind == 4) ? $urandom_range(1, 3) : kind;
    ef.is_fetch = 1'b1; ef.is_write = 1'b0; ef.addr = $urandom & 32'hFFFF_FFFC; ef.wdata = '0;
    ed.is_fetch = 1'b0; ed.is_write = (dtype != 1); ed.addr = $urandom & 32'hFFFF_FFFC; ed.wdata = $urandom;
    if (kind == 0) begin
      exp_q.push_back(ef); last_data = 1'b0; pending = 1;
    end else if (kind < 4) begin
      exp_q.push_back(ed); last_data = 1'b1; pending = 1;
    end else begin
      dfirst = !last_data;
      if (dfirst) begin exp_q.push_back(ed); exp_q.push_back(ef); end
      else        begin exp_q.push_back(ef); exp_q.push_back(ed); end
      last_data = !dfirst;
      pending = 2;
    end
    i_addr = ef.addr; d_addr = ed.addr; d_wdata = ed.wdata;
    i_req = (kind == 0) || (kind == 4);
    d_ren = (kind != 0) && (dtype == 1 || dtype == 3);
    d_wen = (kind != 0) && (dtype == 2 || dtype == 3);
    cyc = 0; stalls = 0;
    while (pending > 0 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if ((ram_ren || ram_wen) && ram_busy) stalls++;
      if (drop && cyc == 1) begin
        i_req = 1'b0; d_ren = 1'b0; d_wen = 1'b0;
        i_addr = $urandom; d_addr = $urandom; d_wdata = $urandom;
      end
      if (i_ready || d_ready) begin
        pending--;
        if (kind < 4) chk("latency", cyc, LAT + 1 + stalls);
        if (i_ready) i_req = 1'b0;
        if (d_ready) begin d_ren = 1'b0; d_wen = 1'b0; end
      end
    end
    if (pending > 0) begin
      chk("timeout", pending, 0);
      exp_q.delete();
    end
    i_req = 1'b0; d_ren = 1'b0; d_wen = 1'b0;
    repeat ($urandom_range(1, 3)) @(negedge clk);
  endtask

  // PRIORITY=1 instance: data must win both collisions.
  initial begin
    int got, cyc;
    bit first_data;
    p1_done = 1'b0;
    p1_i_req = 1'b0; p1_d_ren = 1'b0; p1_d_wen = 1'b0;
    p1_i_addr = 32'h40; p1_d_addr = 32'h80; p1_d_wdata = 32'h0;
    @(posedge nRST);
    repeat (2) @(negedge clk);
    for (int r = 0; r < 2; r++) begin
      p1_i_req = 1'b1; p1_d_ren = 1'b1;
      got = 0; cyc = 0; first_data = 1'b0;
      while (got < 2 && cyc < 60) begin
        @(negedge clk);
        cyc++;
        if (p1_d_ready) begin
          if (got == 0) first_data = 1'b1;
          chk("p1_d_rdata", p1_d_rdata, ramf(32'h80));
          p1_d_ren = 1'b0; got++;
        end
        if (p1_i_ready) begin
          chk("p1_i_rdata", p1_i_rdata, ramf(32'h40));
          p1_i_req = 1'b0; got++;
        end
      end
      chk("p1_data_first", {31'd0, first_data}, 32'd1);
      chk("p1_both_done", got, 2);
      p1_i_req = 1'b0; p1_d_ren = 1'b0;
      repeat (2) @(negedge clk);
    end
    p1_done = 1'b1;
  end

  initial begin
    int cyc, k;
    exp_t ef;
    i_req = 1'b0; d_ren = 1'b0; d_wen = 1'b0; i_addr = '0; d_addr = '0; d_wdata = '0;
    busy_en = 1'b0; last_data = 1'b1; exp_irdata = '0; exp_drdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_wdata", ram_wdata, 0);
    chk("rst_i_rdata", i_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    chk("rst_flags", {26'd0, ram_ren, ram_wen, i_ready, d_ready, busy, 1'b0}, 0);
    nRST = 1'b1;
    repeat (2) @(negedge clk);

    run_txn(4, 1'b0);
    run_txn(4, 1'b0);
    run_txn(2, 1'b0);
    run_txn(3, 1'b0);
    busy_en = 1'b1;
    for (int t = 0; t < 200; t++) begin
      k = $urandom_range(0, 4);
      run_txn(k, (k < 4) && ($urandom_range(0, 3) == 0));
    end

    // Asynchronous reset in the second ACCESS cycle of a fetch.
    busy_en = 1'b0;
    repeat (2) @(negedge clk);
    ef.is_fetch = 1'b1; ef.is_write = 1'b0; ef.addr = 32'h10; ef.wdata = '0;
    i_addr = 32'h10; i_req = 1'b1;
    exp_q.push_back(ef);
    @(posedge clk);
    @(posedge clk);
    #2 nRST = 1'b0;
    #1;
    chk("arst_ram_addr", ram_addr, 0);
    chk("arst_ram_wdata", ram_wdata, 0);
    chk("arst_i_rdata", i_rdata, 0);
    chk("arst_d_rdata", d_rdata, 0);
    chk("arst_flags", {26'd0, ram_ren, ram_wen, i_ready, d_ready, busy, 1'b0}, 0);
    exp_q.delete();
    last_data = 1'b1; exp_irdata = '0; exp_drdata = '0;
    @(negedge clk);
    #2 nRST = 1'b1;
    exp_q.push_back(ef);
    last_data = 1'b0;
    cyc = 0;
    while (!i_ready && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("post_reset_latency", cyc, LAT + 1);
    i_req = 1'b0;
    repeat (2) @(negedge clk);
    run_txn(4, 1'b0);

    cyc = 0;
    while (!p1_done && cyc < 1000) begin
      @(negedge clk);
      cyc++;
    end
    chk("p1_finished", {31'd0, p1_done}, 32'd1);
    chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
